// File: rtl/wx_mem_pkg.sv
// Shared types and constants for the W/X memory responder.
package wx_mem_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } state_t;

  localparam int W_ERR = 0;
  localparam int X_ERR = 1;

endpackage

// File: rtl/wx_bank_mem.sv
// One banked store: array, registered read port, clear write port and
// per-port violation detection. Violations are reported as a one-cycle pulse.
module wx_bank_mem #(
  parameter int DEPTH_LOG2 = 10,
  parameter int SEL_LEN    = 2,
  parameter int DATA_LEN   = 1,
  parameter int ADDR_LEN   = 20,
  parameter int CNT_LEN    = 10
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clearing,
  input  logic [CNT_LEN-1:0]  clr_idx,
  input  logic                wx_write,
  input  logic [ADDR_LEN-1:0] addr,
  input  logic [SEL_LEN-1:0]  sel,
  input  logic                rq,
  input  logic                wq,
  input  logic [DATA_LEN-1:0] wdata,
  output logic [DATA_LEN-1:0] data,
  output logic                dvalid,
  output logic                viol
);

  localparam int NBANK = 1 << SEL_LEN;
  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [DATA_LEN-1:0]   mem_q [NBANK][DEPTH];
  logic [DATA_LEN-1:0]   data_q, data_d;
  logic                  dvalid_q, dvalid_d;
  logic [DEPTH_LOG2-1:0] idx_s;
  logic [DEPTH_LOG2-1:0] clr_row_s;
  logic                  addr_ok_s;
  logic                  clr_ok_s;
  logic                  we_s;
  logic                  viol_s;

  // Decode the request: write enable, read result, dvalid and violation.
  always_comb begin
    idx_s     = addr[DEPTH_LOG2-1:0];
    addr_ok_s = ((addr >> DEPTH_LOG2) == {ADDR_LEN{1'b0}});
    clr_row_s = clr_idx[DEPTH_LOG2-1:0];
    // Counter values beyond this store's depth are ignored.
    clr_ok_s  = clearing && ((clr_idx >> DEPTH_LOG2) == {CNT_LEN{1'b0}});
    we_s      = 1'b0;
    viol_s    = 1'b0;
    dvalid_d  = 1'b0;
    data_d    = data_q;
    if (clearing) begin
      // Requests during a clear are dropped.
      viol_s = rq | wq;
    end else if (wq) begin
      // A write (possibly with a colliding read) never produces dvalid.
      we_s   = wx_write & addr_ok_s;
      viol_s = rq | ~wx_write | ~addr_ok_s;
    end else if (rq) begin
      dvalid_d = 1'b1;
      if (addr_ok_s) begin
        data_d = mem_q[sel][idx_s];
        viol_s = 1'b0;
      end else begin
        data_d = {DATA_LEN{1'b0}};
        viol_s = 1'b1;
      end
    end else begin
      viol_s = 1'b0;
    end
  end

  // Array write port: the clear zeroes one row across all banks per cycle.
  always_ff @(posedge clk) begin
    if (clr_ok_s) begin
      for (int b = 0; b < NBANK; b++) begin
        mem_q[b][clr_row_s] <= {DATA_LEN{1'b0}};
      end
    end else if (we_s) begin
      mem_q[sel][idx_s] <= wdata;
    end
  end

  // Registered read data and its one-cycle valid pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_q   <= {DATA_LEN{1'b0}};
      dvalid_q <= 1'b0;
    end else begin
      data_q   <= data_d;
      dvalid_q <= dvalid_d;
    end
  end

  assign data   = data_q;
  assign dvalid = dvalid_q;
  assign viol   = viol_s;

endmodule

// File: rtl/wx_mem_responder.sv
// W/X memory responder top: clear FSM, clear counter, sticky error flags,
// and one banked store per request interface.
module wx_mem_responder
  import wx_mem_pkg::*;
#(
  parameter int W_ADDR_LEN   = 20,
  parameter int W_DEPTH_LOG2 = 10,
  parameter int W_SEL_LEN    = 2,
  parameter int X_ADDR_LEN   = 10,
  parameter int X_DEPTH_LOG2 = 10,
  parameter int X_SEL_LEN    = 2,
  parameter int DATA_LEN     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wx_write,
  input  logic                  clr,
  output logic                  busy,
  input  logic [W_ADDR_LEN-1:0] w_addr,
  input  logic [W_SEL_LEN-1:0]  w_sel,
  input  logic                  w_rq,
  input  logic                  w_wq,
  input  logic [DATA_LEN-1:0]   w_wdata,
  output logic [DATA_LEN-1:0]   w_data,
  output logic                  w_dvalid,
  input  logic [X_ADDR_LEN-1:0] x_addr,
  input  logic [X_SEL_LEN-1:0]  x_sel,
  input  logic                  x_rq,
  input  logic                  x_wq,
  input  logic [DATA_LEN-1:0]   x_wdata,
  output logic [DATA_LEN-1:0]   x_data,
  output logic                  x_dvalid,
  output logic [1:0]            err
);

  localparam int CNT_LEN = (W_DEPTH_LOG2 > X_DEPTH_LOG2) ? W_DEPTH_LOG2 : X_DEPTH_LOG2;

  state_t             state_q, state_d;
  logic [CNT_LEN-1:0] counter_q, counter_d;
  logic               busy_q, busy_d;
  logic [1:0]         err_q, err_d;
  logic               clearing_s;
  logic               w_viol_s;
  logic               x_viol_s;

  assign clearing_s = (state_q == CLEAR);

  // Next-state logic for the clear sequencer and the sticky error flags.
  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    case (state_q)
      IDLE: begin
        counter_d = {CNT_LEN{1'b0}};
        if (clr) begin
          state_d = CLEAR;
        end else begin
          state_d = IDLE;
        end
      end
      CLEAR: begin
        if (counter_q == {CNT_LEN{1'b1}}) begin
          state_d   = IDLE;
          counter_d = {CNT_LEN{1'b0}};
        end else begin
          state_d   = CLEAR;
          counter_d = counter_q + {{(CNT_LEN-1){1'b0}}, 1'b1};
        end
      end
      default: begin
        state_d   = IDLE;
        counter_d = {CNT_LEN{1'b0}};
      end
    endcase
    busy_d        = (state_d == CLEAR);
    err_d         = err_q;
    err_d[W_ERR]  = err_q[W_ERR] | w_viol_s;
    err_d[X_ERR]  = err_q[X_ERR] | x_viol_s;
  end

  // State, counter and registered status outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= IDLE;
      counter_q <= {CNT_LEN{1'b0}};
      busy_q    <= 1'b0;
      err_q     <= 2'b00;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      busy_q    <= busy_d;
      err_q     <= err_d;
    end
  end

  assign busy = busy_q;
  assign err  = err_q;

  wx_bank_mem #(
    .DEPTH_LOG2 (W_DEPTH_LOG2),
    .SEL_LEN    (W_SEL_LEN),
    .DATA_LEN   (DATA_LEN),
    .ADDR_LEN   (W_ADDR_LEN),
    .CNT_LEN    (CNT_LEN)
  ) u_w_mem (
    .clk      (clk),
    .rst      (rst),
    .clearing (clearing_s),
    .clr_idx  (counter_q),
    .wx_write (wx_write),
    .addr     (w_addr),
    .sel      (w_sel),
    .rq       (w_rq),
    .wq       (w_wq),
    .wdata    (w_wdata),
    .data     (w_data),
    .dvalid   (w_dvalid),
    .viol     (w_viol_s)
  );

  wx_bank_mem #(
    .DEPTH_LOG2 (X_DEPTH_LOG2),
    .SEL_LEN    (X_SEL_LEN),
    .DATA_LEN   (DATA_LEN),
    .ADDR_LEN   (X_ADDR_LEN),
    .CNT_LEN    (CNT_LEN)
  ) u_x_mem (
    .clk      (clk),
    .rst      (rst),
    .clearing (clearing_s),
    .clr_idx  (counter_q),
    .wx_write (wx_write),
    .addr     (x_addr),
    .sel      (x_sel),
    .rq       (x_rq),
    .wq       (x_wq),
    .wdata    (x_wdata),
    .data     (x_data),
    .dvalid   (x_dvalid),
    .viol     (x_viol_s)
  );

endmodule

// File: tb/tb_wx_mem_responder.sv
// Self-checking bench for wx_mem_responder: directed steps plus a random
// phase, all checked against a behavioural model of the two stores.
module tb_wx_mem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        wx_write;
  logic        clr;
  logic        busy;
  logic [19:0] w_addr;
  logic [1:0]  w_sel;
  logic        w_rq, w_wq;
  logic [0:0]  w_wdata, w_data;
  logic        w_dvalid;
  logic [9:0]  x_addr;
  logic [1:0]  x_sel;
  logic        x_rq, x_wq;
  logic [0:0]  x_wdata, x_data;
  logic        x_dvalid;
  logic [1:0]  err;

  int checks   = 0;
  int failures = 0;

  // Behavioural model state
  bit       mem [2][4][1024];
  bit       exp_dv [2];
  bit       exp_data [2];
  bit [1:0] m_err;
  bit       m_busy;
  int       m_cnt;

  always #5 clk = ~clk;

  wx_mem_responder dut (
    .clk(clk), .rst(rst), .wx_write(wx_write), .clr(clr), .busy(busy),
    .w_addr(w_addr), .w_sel(w_sel), .w_rq(w_rq), .w_wq(w_wq),
    .w_wdata(w_wdata), .w_data(w_data), .w_dvalid(w_dvalid),
    .x_addr(x_addr), .x_sel(x_sel), .x_rq(x_rq), .x_wq(x_wq),
    .x_wdata(x_wdata), .x_data(x_data), .x_dvalid(x_dvalid),
    .err(err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    exp_dv[0] = 1'b0; exp_dv[1] = 1'b0;
    exp_data[0] = 1'b0; exp_data[1] = 1'b0;
    m_err = 2'b00; m_busy = 1'b0; m_cnt = 0;
  endtask

  // One port's reaction to a request while the block is idle.
  task automatic serve(input int p, input bit rq, input bit wq, input int sel,
                       input int addr, input bit wd);
    bit inr;
    inr = (addr < 1024);
    exp_dv[p] = 1'b0;
    if (rq && !wq) begin
      exp_dv[p] = 1'b1;
      if (inr) begin
        exp_data[p] = mem[p][sel][addr];
      end else begin
        exp_data[p] = 1'b0;
        m_err[p] = 1'b1;
      end
    end else if (wq) begin
      if (wx_write && inr) mem[p][sel][addr] = wd;
      if (rq || !wx_write || !inr) m_err[p] = 1'b1;
    end
  endtask

  task automatic model_step();
    if (rst) begin
      if (m_busy) begin
        exp_dv[0] = 1'b0; exp_dv[1] = 1'b0;
        if (w_rq || w_wq) m_err[0] = 1'b1;
        if (x_rq || x_wq) m_err[1] = 1'b1;
        for (int p = 0; p < 2; p++)
          for (int b = 0; b < 4; b++)
            mem[p][b][m_cnt] = 1'b0;
        m_cnt++;
        if (m_cnt == 1024) begin
          m_busy = 1'b0;
          m_cnt = 0;
        end
      end else begin
        serve(0, w_rq, w_wq, int'(w_sel), int'(w_addr), w_wdata[0]);
        serve(1, x_rq, x_wq, int'(x_sel), int'(x_addr), x_wdata[0]);
        if (clr) begin
          m_busy = 1'b1;
          m_cnt = 0;
        end
      end
    end
  endtask

  task automatic check_outputs();
    chk("busy",     32'(busy),     32'(m_busy));
    chk("w_dvalid", 32'(w_dvalid), 32'(exp_dv[0]));
    chk("x_dvalid", 32'(x_dvalid), 32'(exp_dv[1]));
    chk("w_data",   32'(w_data),   32'(exp_data[0]));
    chk("x_data",   32'(x_data),   32'(exp_data[1]));
    chk("err",      32'(err),      32'(m_err));
  endtask

  // One clock: DUT samples, model follows, outputs checked, pulses dropped.
  task automatic cycle();
    @(posedge clk);
    model_step();
    #1;
    check_outputs();
    @(negedge clk);
    w_rq = 1'b0; w_wq = 1'b0; x_rq = 1'b0; x_wq = 1'b0; clr = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    rst = 1'b0; wx_write = 1'b0; clr = 1'b0;
    w_addr = 20'h0; w_sel = 2'd0; w_rq = 1'b0; w_wq = 1'b0; w_wdata = 1'b0;
    x_addr = 10'h0; x_sel = 2'd0; x_rq = 1'b0; x_wq = 1'b0; x_wdata = 1'b0;
    model_reset();

    // Reset state
    #1;
    check_outputs();
    repeat (2) cycle();
    rst = 1'b1;

    // Initial clear so every location has a known value
    clr = 1'b1;
    cycle();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      cycle();
    end
    chk("init_busy_len", 32'(n), 32'd1024);

    // Write W sel=2 addr=5, read it back on the next cycle
    wx_write = 1'b1; w_wq = 1'b1; w_sel = 2'd2; w_addr = 20'd5; w_wdata = 1'b1;
    cycle();
    chk("tp1_no_dvalid_on_write", 32'(w_dvalid), 32'd0);
    w_rq = 1'b1;
    cycle();
    chk("tp1_dvalid", 32'(w_dvalid), 32'd1);
    chk("tp1_data", 32'(w_data), 32'd1);
    chk("tp1_err", 32'(err), 32'd0);
    cycle();
    chk("tp1_dvalid_one_cycle", 32'(w_dvalid), 32'd0);
    chk("tp1_data_held", 32'(w_data), 32'd1);

    // Gated-off X write, then read
    wx_write = 1'b0; x_wq = 1'b1; x_addr = 10'd3; x_sel = 2'd0; x_wdata = 1'b1;
    cycle();
    x_rq = 1'b1;
    cycle();
    chk("tp2_dvalid", 32'(x_dvalid), 32'd1);
    chk("tp2_data", 32'(x_data), 32'd0);
    chk("tp2_err", 32'(err), 32'd2);

    // Simultaneous W read and write
    wx_write = 1'b1; w_rq = 1'b1; w_wq = 1'b1; w_wdata = 1'b1; w_addr = 20'd7; w_sel = 2'd0;
    cycle();
    chk("tp3_no_dvalid", 32'(w_dvalid), 32'd0);
    chk("tp3_err", 32'(err), 32'd3);
    w_rq = 1'b1;
    cycle();
    chk("tp3_dvalid", 32'(w_dvalid), 32'd1);
    chk("tp3_data", 32'(w_data), 32'd1);

    // Out-of-range W read
    w_addr = 20'h00400; w_rq = 1'b1;
    cycle();
    chk("tp4_dvalid", 32'(w_dvalid), 32'd1);
    chk("tp4_data", 32'(w_data), 32'd0);

    // Reset to drop the sticky flags; memory keeps its contents
    rst = 1'b0; model_reset();
    #1;
    chk("rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Fill, clear with a request during busy, read back zeros
    wx_write = 1'b1;
    for (int i = 0; i < 4; i++) begin
      x_wq = 1'b1; x_sel = 2'(i); x_addr = 10'(10 + i); x_wdata = 1'b1;
      w_wq = 1'b1; w_sel = 2'(i); w_addr = 20'(900 + i); w_wdata = 1'b1;
      cycle();
    end
    x_rq = 1'b1; x_sel = 2'd1; x_addr = 10'd11;
    cycle();
    chk("tp5_prefill", 32'(x_data), 32'd1);
    clr = 1'b1;
    cycle();
    n = 0;
    while (busy === 1'b1 && n < 2000) begin
      n++;
      if (n == 5) begin
        x_rq = 1'b1; x_sel = 2'd0; x_addr = 10'd10;
      end
      cycle();
    end
    chk("tp5_busy_len", 32'(n), 32'd1024);
    chk("tp5_err", 32'(err), 32'd2);
    for (int i = 0; i < 4; i++) begin
      x_rq = 1'b1; x_sel = 2'(i); x_addr = 10'(10 + i);
      w_rq = 1'b1; w_sel = 2'(i); w_addr = 20'(900 + i);
      cycle();
      chk("tp5_x_cleared", 32'(x_data), 32'd0);
      chk("tp5_w_cleared", 32'(w_data), 32'd0);
    end

    // Random traffic against the model
    for (int i = 0; i < 400; i++) begin
      wx_write = ($urandom_range(0, 3) != 0);
      w_rq = ($urandom_range(0, 2) == 0);
      w_wq = ($urandom_range(0, 2) == 0);
      w_sel = 2'($urandom_range(0, 3));
      w_addr = ($urandom_range(0, 15) == 0) ? (20'h00400 | 20'($urandom_range(0, 7)))
                                            : 20'($urandom_range(0, 7));
      w_wdata = 1'($urandom_range(0, 1));
      x_rq = ($urandom_range(0, 2) == 0);
      x_wq = ($urandom_range(0, 2) == 0);
      x_sel = 2'($urandom_range(0, 3));
      x_addr = 10'($urandom_range(0, 7));
      x_wdata = 1'($urandom_range(0, 1));
      clr = ($urandom_range(0, 299) == 0);
      cycle();
    end
    n = 0;
    while (m_busy && n < 2000) begin
      n++;
      cycle();
    end

    // Reset in the middle of a clear
    clr = 1'b1;
    cycle();
    x_rq = 1'b1;
    cycle();
    repeat (8) cycle();
    chk("mid_clear_busy", 32'(busy), 32'd1);
    #2;
    rst = 1'b0; model_reset();
    #1;
    chk("mid_clear_rst_busy", 32'(busy), 32'd0);
    chk("mid_clear_rst_err", 32'(err), 32'd0);
    @(negedge clk);
    rst = 1'b1;

    // Reset right after a read result appears
    wx_write = 1'b1; w_wq = 1'b1; w_sel = 2'd1; w_addr = 20'd2; w_wdata = 1'b1;
    cycle();
    w_rq = 1'b1;
    cycle();
    chk("rd_rst_pre_dvalid", 32'(w_dvalid), 32'd1);
    rst = 1'b0; model_reset();
    #1;
    chk("rd_rst_dvalid", 32'(w_dvalid), 32'd0);
    chk("rd_rst_data", 32'(w_data), 32'd0);
    @(negedge clk);
    // Read pending while reset is asserted produces nothing
    w_rq = 1'b1;
    cycle();
    chk("rd_in_rst_dvalid", 32'(w_dvalid), 32'd0);
    rst = 1'b1;
    w_rq = 1'b1; w_sel = 2'd1; w_addr = 20'd2;
    cycle();
    chk("resume_dvalid", 32'(w_dvalid), 32'd1);
    chk("resume_data", 32'(w_data), 32'd1);
    cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
